echo_range_filter: RTL and testbench
====================================

Name: echo_range_filter

Overview:
Downstream stage of the ultrasonic echo timer. It accepts each measured echo pulse width, expressed in clk ticks, and converts it to centimetres using a sequential repeated-subtraction divider. It then applies a hysteresis and consecutive-sample confirmation filter, producing a debounced object_present flag and a per-measurement distance strobe for the game/display logic.

Parameters:
TICKS_PER_CM, 2900, clk ticks of echo per cm of range (58 us/cm at 50 MHz)
MAX_CM, 400, distance clamp; must fit in DIST_W
DIST_W, 9, width of dist_cm
NEAR_CM, 20, sample at or below this counts as "near"
FAR_CM, 25, sample at or above this counts as "far"; must satisfy FAR_CM > NEAR_CM
CONFIRM_N, 3, consecutive contradicting samples required to toggle object_present (1..15)

Ports:
clk  in  1  system clock (50 MHz)
rst  in  1  asynchronous, active-high reset
width_valid  in  1  one-cycle strobe: width_ticks holds a new measurement
width_ticks  in  32  echo high time in clk ticks
width_ready  out  1  high only in IDLE; a measurement is accepted when width_valid & width_ready
dist_valid  out  1  one-cycle strobe: dist_cm and out_of_range are updated
dist_cm  out  DIST_W  truncated distance in cm, clamped to MAX_CM
out_of_range  out  1  last sample was zero-width or beyond MAX_CM
object_present  out  1  filtered presence flag
busy  out  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset: async assert forces FSM=IDLE, width_ready=1, busy=0, dist_valid=0, dist_cm=0, out_of_range=0, object_present=0, confirm counter=0. Any measurement in flight is discarded. Deassert is synchronous to clk.
- FSM states: IDLE, DIVIDE, UPDATE.
- IDLE: on width_valid=1, latch rem<=width_ticks and q<=0, then go to DIVIDE. width_valid seen outside IDLE is ignored: no queue, and the sample is dropped.
- DIVIDE: each cycle, if rem>=TICKS_PER_CM and q<MAX_CM, then rem-=TICKS_PER_CM and q++. Otherwise go to UPDATE.
- UPDATE:
  - dist_cm<=q.
  - out_of_range<=(width_ticks latched ==0) | (rem>=TICKS_PER_CM).
  - Filter update as described below.
  - Go to IDLE. dist_valid=1 for exactly the cycle after UPDATE, coinciding with the return to IDLE.
- Latency: for an accept at edge E0, dist_valid is high after edge E0+q+2, where q is the final quotient. Next accept is possible at the edge where dist_valid is high.
- Arithmetic:
  - Unsigned; rem is 32 bits, q is DIST_W bits.
  - Result truncates: 5799 ticks -> 1 cm.
  - Exact multiple at the cap (MAX_CM*TICKS_PER_CM) -> dist_cm=MAX_CM, out_of_range=0.
- Sample classification, applied in UPDATE:
  - Zero width: no filter action; counter unchanged.
  - near = !oor & q<=NEAR_CM.
  - far = oor | q>=FAR_CM.
  - A sample between NEAR_CM and FAR_CM (exclusive) is neutral.
- Filter:
  - Contradicting sample (near while object_present=0, or far while object_present=1): counter++. When counter reaches CONFIRM_N, toggle object_present and clear the counter in the same cycle. object_present changes with dist_valid.
  - Agreeing or neutral sample: clear the counter.
- Outputs are registered; there are no combinational input-to-output paths except none (width_ready is a state decode).

Decomposition:
- Package echo_range_pkg holds:
  - the state enum (IDLE/DIVIDE/UPDATE);
  - the default constants CLK_FREQ=50000000, TICKS_PER_CM, MAX_CM, NEAR_CM, FAR_CM;
  - a function that derives TICKS_PER_CM from CLK_FREQ.
- One sub-module, range_divider: start/done handshake, rem/q datapath, clamp, and the oor output. The top module keeps the handshake FSM and the hysteresis filter.

Test Plan:
- Reset during DIVIDE (width 290000, rst pulsed 5 cycles after accept) -> no dist_valid; all outputs at reset values; next width 29000 is accepted normally.
- width_ticks=5800 accepted at E0 -> dist_valid after E0+4, dist_cm=2, out_of_range=0, width_ready=0 for 4 cycles.
- Three consecutive 29000-tick samples (10 cm) from reset -> object_present goes 0->1 with the 3rd dist_valid. Then far samples 87000, 87000, 66700 (30, 30, 23 cm) -> counter cleared by the neutral sample, object_present stays 1. Then three more 87000 -> object_present drops to 0 on the 3rd.
- Cap and range boundaries:
  - width 1160000 -> dist_cm=400, oor=0, latency 402.
  - width 1200000 -> dist_cm=400, oor=1, counted as far.
  - width 0 -> oor=1, dist_cm=0, filter and counter untouched.
- width_valid pulsed while busy (a second sample 3 cycles after accepting 58000) -> second sample dropped; exactly one dist_valid with dist_cm=20. Sample 58000 (20 cm) counts as near; 72500 (25 cm) counts as far.

Source files
------------

// File: rtl/echo_range_filter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | echo_range_pkg                                                             |
// | Shared constants, state encoding and tick-rate helper for the echo filter. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package echo_range_pkg;

   localparam int unsigned CLK_FREQ  = 50_000_000;
   localparam int unsigned US_PER_CM = 58;   // round-trip sound time per cm

   function automatic int unsigned calc_ticks_per_cm(input int unsigned clk_freq);
      return (clk_freq / 1_000_000) * US_PER_CM;
   endfunction

   localparam int unsigned TICKS_PER_CM = calc_ticks_per_cm(CLK_FREQ);
   localparam int unsigned MAX_CM       = 400;
   localparam int unsigned DIST_W       = 9;
   localparam int unsigned NEAR_CM      = 20;
   localparam int unsigned FAR_CM       = 25;
   localparam int unsigned CONFIRM_N    = 3;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DIVIDE = 2'd1,
      ST_UPDATE = 2'd2
   } state_t;

endpackage
`default_nettype wire

// File: rtl/echo_range_filter_range_divider.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | range_divider                                                              |
// | Repeated-subtraction ticks-to-cm divider with clamp and out-of-range flag. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module range_divider #(
   parameter int unsigned TICKS_PER_CM = 2900,
   parameter int unsigned MAX_CM       = 400,
   parameter int unsigned DIST_W       = 9
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [31:0]       width,
   output logic              done,
   output logic [DIST_W-1:0] quot,
   output logic              oor,
   output logic              zero
);

   logic [31:0]       r_rem;
   logic [DIST_W-1:0] r_q;
   logic              r_active;
   logic              r_zero;
   logic              w_rem_ge;
   logic              w_step;

   assign w_rem_ge = (r_rem >= 32'(TICKS_PER_CM));
   assign w_step   = r_active && w_rem_ge && (r_q < DIST_W'(MAX_CM));
   assign done     = r_active && !w_step;
   assign quot     = r_q;
   // A leftover full cm after the clamp means the echo was beyond MAX_CM.
   assign oor      = r_zero || w_rem_ge;
   assign zero     = r_zero;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rem    <= '0;
         r_q      <= '0;
         r_active <= 1'b0;
         r_zero   <= 1'b0;
      end else if (start) begin
         r_rem    <= width;
         r_q      <= '0;
         r_active <= 1'b1;
         r_zero   <= (width == 32'd0);
      end else if (w_step) begin
         r_rem    <= r_rem - 32'(TICKS_PER_CM);
         r_q      <= r_q + DIST_W'(1);
      end else if (r_active) begin
         r_active <= 1'b0;
      end
   end

endmodule
`default_nettype wire

// File: rtl/echo_range_filter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | echo_range_filter                                                          |
// | Echo width to cm conversion with hysteresis/confirmation presence filter.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module echo_range_filter #(
   parameter int unsigned TICKS_PER_CM = echo_range_pkg::TICKS_PER_CM,
   parameter int unsigned MAX_CM       = echo_range_pkg::MAX_CM,
   parameter int unsigned DIST_W       = echo_range_pkg::DIST_W,
   parameter int unsigned NEAR_CM      = echo_range_pkg::NEAR_CM,
   parameter int unsigned FAR_CM       = echo_range_pkg::FAR_CM,
   parameter int unsigned CONFIRM_N    = echo_range_pkg::CONFIRM_N
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              width_valid,
   input  logic [31:0]       width_ticks,
   output logic              width_ready,
   output logic              dist_valid,
   output logic [DIST_W-1:0] dist_cm,
   output logic              out_of_range,
   output logic              object_present,
   output logic              busy
);
   import echo_range_pkg::*;

   state_t            r_state;
   logic [3:0]        r_count;
   logic              w_start;
   logic              w_done;
   logic [DIST_W-1:0] w_q;
   logic              w_oor;
   logic              w_zero;
   logic              w_near;
   logic              w_far;
   logic              w_contra;

   assign width_ready = (r_state == ST_IDLE);
   assign busy        = (r_state != ST_IDLE);
   assign w_start     = (r_state == ST_IDLE) && width_valid;

   range_divider #(
      .TICKS_PER_CM (TICKS_PER_CM),
      .MAX_CM       (MAX_CM),
      .DIST_W       (DIST_W)
   ) u_div (
      .clk   (clk),
      .rst   (rst),
      .start (w_start),
      .width (width_ticks),
      .done  (w_done),
      .quot  (w_q),
      .oor   (w_oor),
      .zero  (w_zero)
   );

   // A sample contradicts the current flag when it points the other way.
   assign w_near   = !w_oor && (w_q <= DIST_W'(NEAR_CM));
   assign w_far    = w_oor || (w_q >= DIST_W'(FAR_CM));
   assign w_contra = object_present ? w_far : w_near;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state        <= ST_IDLE;
         r_count        <= 4'd0;
         dist_valid     <= 1'b0;
         dist_cm        <= '0;
         out_of_range   <= 1'b0;
         object_present <= 1'b0;
      end else begin
         dist_valid <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (width_valid) r_state <= ST_DIVIDE;
            end
            ST_DIVIDE: begin
               if (w_done) r_state <= ST_UPDATE;
            end
            ST_UPDATE: begin
               dist_cm      <= w_q;
               out_of_range <= w_oor;
               dist_valid   <= 1'b1;
               r_state      <= ST_IDLE;
               if (!w_zero) begin
                  if (!w_contra) begin
                     r_count <= 4'd0;
                  end else if (r_count == 4'(CONFIRM_N - 1)) begin
                     object_present <= !object_present;
                     r_count        <= 4'd0;
                  end else begin
                     r_count <= r_count + 4'd1;
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_echo_range_filter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_echo_range_filter                                                       |
// | Directed self-checking bench for echo_range_filter.                        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_echo_range_filter;

   logic        clk;
   logic        rst;
   logic        width_valid;
   logic [31:0] width_ticks;
   logic        width_ready;
   logic        dist_valid;
   logic [8:0]  dist_cm;
   logic        out_of_range;
   logic        object_present;
   logic        busy;

   int n_vec = 0;
   int n_err = 0;

   echo_range_filter dut (
      .clk            (clk),
      .rst            (rst),
      .width_valid    (width_valid),
      .width_ticks    (width_ticks),
      .width_ready    (width_ready),
      .dist_valid     (dist_valid),
      .dist_cm        (dist_cm),
      .out_of_range   (out_of_range),
      .object_present (object_present),
      .busy           (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_ready"}, width_ready, 1);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_dv"}, dist_valid, 0);
      chk({tag, "_dist"}, dist_cm, 0);
      chk({tag, "_oor"}, out_of_range, 0);
      chk({tag, "_present"}, object_present, 0);
   endtask

   // Entered #1 after an edge with the DUT idle; accepts one sample and waits for its result.
   task automatic measure(input string tag, input logic [31:0] w, input int exp_cm,
                          input logic exp_oor, input logic exp_pres, input int exp_lat);
      int cyc;
      int lows;
      bit seen;
      width_ticks = w;
      width_valid = 1'b1;
      @(posedge clk); #1;
      width_valid = 1'b0;
      cyc  = 0;
      lows = 0;
      seen = 1'b0;
      while (!seen && cyc < 1000) begin
         if (!width_ready) lows++;
         @(posedge clk); #1;
         cyc++;
         if (dist_valid) seen = 1'b1;
      end
      chk({tag, "_seen"}, seen, 1);
      chk({tag, "_lat"}, cyc, exp_lat);
      chk({tag, "_ready_low"}, lows, exp_lat);
      chk({tag, "_dist"}, dist_cm, exp_cm);
      chk({tag, "_oor"}, out_of_range, exp_oor);
      chk({tag, "_present"}, object_present, exp_pres);
      chk({tag, "_ready_back"}, width_ready, 1);
      @(posedge clk); #1;
      chk({tag, "_dv_pulse"}, dist_valid, 0);
   endtask

   initial begin
      int dv_cnt;
      int cyc;
      bit seen;

      rst         = 1'b1;
      width_valid = 1'b0;
      width_ticks = 32'd0;
      repeat (3) @(posedge clk);
      #1;
      chk_reset_outputs("reset");
      rst = 1'b0;
      @(posedge clk); #1;

      // Near samples from reset confirm presence on the third.
      measure("near10_a", 32'd29000, 10, 1'b0, 1'b0, 12);
      measure("near10_b", 32'd29000, 10, 1'b0, 1'b0, 12);
      measure("near10_c", 32'd29000, 10, 1'b0, 1'b1, 12);
      measure("w5800",    32'd5800,   2, 1'b0, 1'b1, 4);
      measure("w5799",    32'd5799,   1, 1'b0, 1'b1, 3);
      measure("far_pre",  32'd87000, 30, 1'b0, 1'b1, 32);

      // Reset in the middle of a long division (counter holds 1 at this point).
      width_ticks = 32'd290000;
      width_valid = 1'b1;
      @(posedge clk); #1;
      width_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      chk("mid_div_busy", busy, 1);
      rst = 1'b1;
      #1;
      chk_reset_outputs("async_rst");
      @(posedge clk);
      @(posedge clk); #1;
      rst = 1'b0;
      dv_cnt = 0;
      for (int i = 0; i < 150; i++) begin
         @(posedge clk); #1;
         if (dist_valid) dv_cnt++;
      end
      chk("rst_drop_dv", dv_cnt, 0);
      chk_reset_outputs("post_rst");

      measure("rnear_a", 32'd29000, 10, 1'b0, 1'b0, 12);
      measure("rnear_b", 32'd29000, 10, 1'b0, 1'b0, 12);
      measure("rnear_c", 32'd29000, 10, 1'b0, 1'b1, 12);

      // Neutral sample clears the far count.
      measure("far_a",   32'd87000, 30, 1'b0, 1'b1, 32);
      measure("far_b",   32'd87000, 30, 1'b0, 1'b1, 32);
      measure("neutral", 32'd66700, 23, 1'b0, 1'b1, 25);
      measure("far_c",   32'd87000, 30, 1'b0, 1'b1, 32);
      measure("far_d",   32'd87000, 30, 1'b0, 1'b1, 32);
      measure("far_e",   32'd87000, 30, 1'b0, 1'b0, 32);

      // 20 cm is near.
      measure("near20_a", 32'd58000, 20, 1'b0, 1'b0, 22);
      measure("near20_b", 32'd58000, 20, 1'b0, 1'b0, 22);
      measure("near20_c", 32'd58000, 20, 1'b0, 1'b1, 22);

      // 25 cm, beyond-cap and exact-cap are far; zero width leaves the count alone.
      measure("far25",    32'd25 * 32'd2900, 25, 1'b0, 1'b1, 27);
      measure("over_cap", 32'd1200000, 400, 1'b1, 1'b1, 402);
      measure("zero",     32'd0,         0, 1'b1, 1'b1, 2);
      measure("at_cap",   32'd1160000, 400, 1'b0, 1'b0, 402);

      // Second strobe while busy is dropped.
      width_ticks = 32'd58000;
      width_valid = 1'b1;
      @(posedge clk); #1;
      width_valid = 1'b0;
      @(posedge clk);
      @(posedge clk); #1;
      width_ticks = 32'd5800;
      width_valid = 1'b1;
      @(posedge clk); #1;
      width_valid = 1'b0;
      cyc  = 3;
      seen = 1'b0;
      while (!seen && cyc < 1000) begin
         @(posedge clk); #1;
         cyc++;
         if (dist_valid) seen = 1'b1;
      end
      chk("busy_drop_seen", seen, 1);
      chk("busy_drop_lat", cyc, 22);
      chk("busy_drop_dist", dist_cm, 20);
      dv_cnt = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (dist_valid) dv_cnt++;
      end
      chk("busy_drop_extra_dv", dv_cnt, 0);
      chk("busy_drop_idle", busy, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
